// File: rtl/uart_rx_cmd.sv
// 8N1 UART receiver with 16x oversampling that gathers PKT_BYTES bytes into one command word
// and pushes each complete word into the inbound command FIFO.
module uart_rx_cmd #(
  parameter int unsigned CLK_FREQ_HZ  = 100000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned PKT_BYTES    = 4,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_data,
  input  logic                   cmd_fifo_full,
  output logic                   cmd_fifo_wr_en,
  output logic [PKT_BYTES*8-1:0] cmd_fifo_wr_data,
  output logic [7:0]             rx_byte,
  output logic                   rx_byte_valid,
  output logic                   rx_busy,
  output logic                   frame_err,
  output logic                   overflow_err,
  output logic                   timeout_err
);

  localparam int unsigned W        = PKT_BYTES * 8;
  localparam int unsigned DIV      = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned DivW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SampW    = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW     = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam int unsigned TO_TICKS = TIMEOUT_BITS * OVERSAMPLE;
  localparam int unsigned ToW      = $clog2(TO_TICKS);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e            state;
  logic              rx_meta, rx_s;
  logic [DivW-1:0]   div_cnt;
  logic [SampW-1:0]  samp_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic [W-9:0]      sr;
  logic [IdxW-1:0]   idx;
  logic [ToW-1:0]    to_cnt;
  logic              tick;
  logic              samp_mid, samp_end;
  logic [W-1:0]      word_nxt;

  assign tick     = (div_cnt == DivW'(DIV - 1));
  assign samp_mid = tick && (samp_cnt == SampW'(OVERSAMPLE / 2 - 1));
  assign samp_end = tick && (samp_cnt == SampW'(OVERSAMPLE - 1));
  assign word_nxt = {sr, rx_byte};
  assign rx_busy  = (state != StIdle);

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_data;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= StIdle;
      div_cnt          <= '0;
      samp_cnt         <= '0;
      bit_cnt          <= '0;
      shift            <= '0;
      sr               <= '0;
      idx              <= '0;
      to_cnt           <= '0;
      rx_byte          <= '0;
      rx_byte_valid    <= 1'b0;
      frame_err        <= 1'b0;
      overflow_err     <= 1'b0;
      timeout_err      <= 1'b0;
      cmd_fifo_wr_en   <= 1'b0;
      cmd_fifo_wr_data <= '0;
    end else begin
      rx_byte_valid  <= 1'b0;
      frame_err      <= 1'b0;
      overflow_err   <= 1'b0;
      timeout_err    <= 1'b0;
      cmd_fifo_wr_en <= 1'b0;
      div_cnt        <= tick ? '0 : div_cnt + 1'b1;
      if (tick) samp_cnt <= samp_cnt + 1'b1;

      // Timeout only runs on an idle, high line; a start edge clears it, so it wins a tie.
      if (idx == '0 || state != StIdle || !rx_s) begin
        to_cnt <= '0;
      end else if (tick) begin
        if (to_cnt == ToW'(TO_TICKS - 1)) begin
          timeout_err <= 1'b1;
          idx         <= '0;
          to_cnt      <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end

      if (rx_byte_valid) begin
        sr <= word_nxt[W-9:0];
        if (idx == IdxW'(PKT_BYTES - 1)) begin
          idx            <= '0;
          cmd_fifo_wr_en <= !cmd_fifo_full;
          overflow_err   <= cmd_fifo_full;
          if (!cmd_fifo_full) cmd_fifo_wr_data <= word_nxt;
        end else begin
          idx <= idx + 1'b1;
        end
      end

      unique case (state)
        StIdle: begin
          if (!rx_s) begin
            state    <= StStart;
            div_cnt  <= '0;
            samp_cnt <= '0;
          end
        end
        StStart: begin
          if (samp_mid) begin
            samp_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? StIdle : StData;
          end
        end
        StData: begin
          if (samp_end) begin
            samp_cnt <= '0;
            shift    <= {rx_s, shift[7:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= StStop;
          end
        end
        StStop: begin
          if (samp_end) begin
            samp_cnt <= '0;
            if (rx_s) begin
              rx_byte       <= shift;
              rx_byte_valid <= 1'b1;
              state         <= StIdle;
            end else begin
              frame_err <= 1'b1;
              idx       <= '0;
              state     <= StBreak;
            end
          end
        end
        StBreak: begin
          if (rx_s) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Directed bench for uart_rx_cmd: table of whole packets plus hand-written corner sequences.
module tb_uart_rx_cmd;

  localparam int BIT = 160;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_data = 1'b1;
  logic        cmd_fifo_full = 1'b0;
  logic        cmd_fifo_wr_en;
  logic [31:0] cmd_fifo_wr_data;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        rx_busy;
  logic        frame_err;
  logic        overflow_err;
  logic        timeout_err;

  uart_rx_cmd #(
    .CLK_FREQ_HZ (1600000),
    .BAUD        (10000),
    .OVERSAMPLE  (16),
    .PKT_BYTES   (4),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .cmd_fifo_full   (cmd_fifo_full),
    .cmd_fifo_wr_en  (cmd_fifo_wr_en),
    .cmd_fifo_wr_data(cmd_fifo_wr_data),
    .rx_byte         (rx_byte),
    .rx_byte_valid   (rx_byte_valid),
    .rx_busy         (rx_busy),
    .frame_err       (frame_err),
    .overflow_err    (overflow_err),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  int n_valid = 0, n_wr = 0, n_ferr = 0, n_oerr = 0, n_terr = 0;
  logic [31:0] last_wr = '0;

  always @(negedge clk) begin
    if (rx_byte_valid) n_valid++;
    if (cmd_fifo_wr_en) begin
      n_wr++;
      last_wr = cmd_fifo_wr_data;
    end
    if (frame_err) n_ferr++;
    if (overflow_err) n_oerr++;
    if (timeout_err) n_terr++;
  end

  int tests = 0, failed = 0;
  int b_valid, b_wr, b_ferr, b_oerr, b_terr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic snap();
    b_valid = n_valid; b_wr = n_wr; b_ferr = n_ferr; b_oerr = n_oerr; b_terr = n_terr;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_data = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_data = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx_data = stop;
    repeat (BIT) @(negedge clk);
    rx_data = 1'b1;
  endtask

  task automatic send_pkt(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
    repeat (40) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] word;
    logic        full;
    int          exp_wr;
    int          exp_ovf;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[3];
  logic saw_busy;

  initial begin
    vecs[0] = '{32'hDEADBEEF, 1'b0, 1, 0, 32'hDEADBEEF};
    vecs[1] = '{32'hCAFE0055, 1'b1, 0, 1, 32'hDEADBEEF};
    vecs[2] = '{32'h00FF8001, 1'b0, 1, 0, 32'h00FF8001};

    repeat (3) @(negedge clk);
    check("reset_outputs_zero", {cmd_fifo_wr_en, cmd_fifo_wr_data, rx_byte, rx_byte_valid,
                                 rx_busy, frame_err, overflow_err, timeout_err}, 64'd0);
    rst = 1'b0;
    repeat (BIT) @(negedge clk);
    check("idle_after_reset", {rx_busy, cmd_fifo_wr_en}, 64'd0);

    // Whole packets, back-to-back bytes, with and without FIFO backpressure.
    for (int v = 0; v < 3; v++) begin
      cmd_fifo_full = vecs[v].full;
      snap();
      send_pkt(vecs[v].word);
      check($sformatf("vec%0d_valid_cnt", v), n_valid - b_valid, 4);
      check($sformatf("vec%0d_wr_cnt", v), n_wr - b_wr, vecs[v].exp_wr);
      check($sformatf("vec%0d_ovf_cnt", v), n_oerr - b_oerr, vecs[v].exp_ovf);
      check($sformatf("vec%0d_ferr_terr", v), (n_ferr - b_ferr) + (n_terr - b_terr), 0);
      check($sformatf("vec%0d_wr_data", v), cmd_fifo_wr_data, vecs[v].exp_data);
      check($sformatf("vec%0d_last_byte", v), rx_byte, vecs[v].word[7:0]);
    end
    cmd_fifo_full = 1'b0;
    check("strobe_data_0x00FF8001", last_wr, 32'h00FF8001);

    // 40-clk glitch on an idle line.
    snap();
    saw_busy = 1'b0;
    rx_data = 1'b0;
    for (int i = 0; i < 90; i++) begin
      if (i == 40) rx_data = 1'b1;
      @(negedge clk);
      if (rx_busy) saw_busy = 1'b1;
    end
    check("glitch_busy_seen", saw_busy, 1);
    check("glitch_busy_cleared", rx_busy, 0);
    check("glitch_no_byte", n_valid - b_valid, 0);
    send_byte(8'h55, 1'b1);
    repeat (40) @(negedge clk);
    check("after_glitch_valid", n_valid - b_valid, 1);
    check("after_glitch_byte", rx_byte, 8'h55);
    // The lone 0x55 is a partial packet and must time out.
    repeat (25 * BIT) @(negedge clk);
    check("lone_byte_timeout", n_terr - b_terr, 1);
    check("lone_byte_no_wr", n_wr - b_wr, 0);

    // Stop bit low, line held in break, then a clean packet.
    snap();
    send_byte(8'hA5, 1'b0);
    rx_data = 1'b0;
    repeat (500) @(negedge clk);
    rx_data = 1'b1;
    repeat (BIT) @(negedge clk);
    send_pkt(32'h11223344);
    check("break_ferr_cnt", n_ferr - b_ferr, 1);
    check("break_valid_cnt", n_valid - b_valid, 4);
    check("break_wr_cnt", n_wr - b_wr, 1);
    check("break_wr_data", last_wr, 32'h11223344);

    // Two bytes, 21 idle bit-times, then a full packet.
    snap();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (21 * BIT) @(negedge clk);
    check("timeout_fired", n_terr - b_terr, 1);
    check("timeout_no_wr", n_wr - b_wr, 0);
    send_pkt(32'h03040506);
    check("timeout_terr_once", n_terr - b_terr, 1);
    check("timeout_wr_cnt", n_wr - b_wr, 1);
    check("timeout_wr_data", last_wr, 32'h03040506);

    // Reset midway through the second byte of a packet.
    snap();
    send_byte(8'h77, 1'b1);
    rx_data = 1'b0;
    repeat (BIT) @(negedge clk);
    rx_data = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_outputs_zero", {cmd_fifo_wr_en, cmd_fifo_wr_data, rx_byte, rx_byte_valid,
                                    rx_busy, frame_err, overflow_err, timeout_err}, 64'd0);
    check("midreset_no_wr", n_wr - b_wr, 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (BIT) @(negedge clk);
    snap();
    send_pkt(32'h10203040);
    check("postreset_wr_cnt", n_wr - b_wr, 1);
    check("postreset_wr_data", last_wr, 32'h10203040);
    check("postreset_valid_cnt", n_valid - b_valid, 4);
    repeat (22 * BIT) @(negedge clk);
    check("postreset_no_timeout", n_terr - b_terr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
